// File: rtl/array_access_pkg.sv
// Shared defaults and FSM encoding for the array access controller.
package array_access_pkg;

  localparam int DEF_DEPTH  = 128;
  localparam int DEF_WIDTH  = 51;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/array_resp_hold.sv
// Read response stage: turns the macro's one-cycle read into a ready/valid response
// and keeps the data stable in a hold register while the client stalls.
module array_resp_hold
  import array_access_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_fire,
  input  logic [WIDTH-1:0] fresh_data,
  input  logic             rresp_ready,
  output logic             rresp_valid,
  output logic [WIDTH-1:0] rresp_data
);

  logic             valid_q;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      hold_valid <= 1'b0;
      hold_q     <= '0;
    end else if (rd_fire) begin
      valid_q    <= 1'b1;
      hold_valid <= 1'b0;
    end else if (valid_q && rresp_ready) begin
      valid_q    <= 1'b0;
      hold_valid <= 1'b0;
    end else if (valid_q && !hold_valid) begin
      // First stalled cycle: macro output is only valid now, so capture it.
      hold_valid <= 1'b1;
      hold_q     <= fresh_data;
    end
  end

  assign rresp_valid = valid_q;
  assign rresp_data  = (valid_q && !hold_valid) ? fresh_data : hold_q;

endmodule

// File: rtl/array_access_ctrl.sv
// Requester-side controller for a 1R1W array macro. The zero-init sweep after reset
// is built only when ARRAY_ACCESS_INIT_EN is defined; otherwise reset goes straight to RUN.
module array_access_ctrl
  import array_access_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rreq_valid,
  output logic              rreq_ready,
  input  logic [ADDR_W-1:0] rreq_addr,
  output logic              rresp_valid,
  input  logic              rresp_ready,
  output logic [WIDTH-1:0]  rresp_data,
  input  logic              wreq_valid,
  output logic              wreq_ready,
  input  logic [ADDR_W-1:0] wreq_addr,
  input  logic [WIDTH-1:0]  wreq_data,
  output logic              init_done,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [WIDTH-1:0]  sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [WIDTH-1:0]  sram_w_data,
  output logic              sram_w_mask
);

  localparam logic [0:0] ST_RUN = 1'(RUN);

  logic [0:0]        state;
  logic              init_done_q;
  logic              sweep_active;
  logic [ADDR_W-1:0] sweep_addr;
  logic              run;
  logic              rd_ready;
  logic              rd_fire;
  logic              wr_fire;
  logic              byp_hit;
  logic [WIDTH-1:0]  byp_data;
  logic [WIDTH-1:0]  fresh_data;

`ifdef ARRAY_ACCESS_INIT_EN
  localparam logic [0:0]        ST_INIT   = 1'(INIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] sweep_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_INIT;
      sweep_cnt   <= '0;
      init_done_q <= 1'b0;
    end else if (state == ST_INIT) begin
      // The counter wraps to 0 on the same edge that leaves INIT.
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == LAST_ADDR) begin
        state       <= ST_RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  assign sweep_active = (state == ST_INIT);
  assign sweep_addr   = sweep_cnt;
`else
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RUN;
      init_done_q <= 1'b0;
    end else begin
      init_done_q <= 1'b1;
    end
  end

  assign sweep_active = 1'b0;
  assign sweep_addr   = '0;
`endif

  // init_done_q keeps both ready outputs low during the reset cycle and the sweep.
  assign run        = (state == ST_RUN) && init_done_q;
  assign init_done  = init_done_q;
  assign rd_ready   = run && (!rresp_valid || rresp_ready);
  assign rreq_ready = rd_ready;
  assign wreq_ready = run;
  assign rd_fire    = rreq_valid && rd_ready;
  assign wr_fire    = wreq_valid && run;

  assign sram_r_en   = rd_fire;
  assign sram_r_addr = rreq_addr;

  always_comb begin
    sram_w_en   = 1'b0;
    sram_w_addr = wreq_addr;
    sram_w_data = wreq_data;
    if (sweep_active) begin
      sram_w_en   = 1'b1;
      sram_w_addr = sweep_addr;
      sram_w_data = '0;
    end else if (wr_fire) begin
      sram_w_en = 1'b1;
    end
  end

  assign sram_w_mask = sram_w_en;

  // The macro's same-address behaviour is not relied on: a colliding write is
  // replayed into the response so reads observe write-first semantics.
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= rd_fire && wr_fire && (rreq_addr == wreq_addr);
      if (rd_fire && wr_fire) begin
        byp_data <= wreq_data;
      end
    end
  end

  assign fresh_data = byp_hit ? byp_data : sram_r_data;

  array_resp_hold #(
    .WIDTH (WIDTH)
  ) u_resp_hold (
    .clock       (clock),
    .reset       (reset),
    .rd_fire     (rd_fire),
    .fresh_data  (fresh_data),
    .rresp_ready (rresp_ready),
    .rresp_valid (rresp_valid),
    .rresp_data  (rresp_data)
  );

endmodule

// File: tb/tb_array_access_ctrl.sv
// Bench for array_access_ctrl: behavioural macro, array reference model with a
// response queue, directed scenarios followed by randomized traffic.
module tb_array_access_ctrl;
  import array_access_pkg::*;

  localparam int DEPTH = DEF_DEPTH;
  localparam int WIDTH = DEF_WIDTH;
  localparam int AW    = DEF_ADDR_W;
`ifdef ARRAY_ACCESS_INIT_EN
  localparam bit INIT_EN  = 1'b1;
  localparam int READY_AT = DEPTH;
`else
  localparam bit INIT_EN  = 1'b0;
  localparam int READY_AT = 1;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             rreq_valid = 1'b0;
  logic             rreq_ready;
  logic [AW-1:0]    rreq_addr = '0;
  logic             rresp_valid;
  logic             rresp_ready = 1'b1;
  logic [WIDTH-1:0] rresp_data;
  logic             wreq_valid = 1'b0;
  logic             wreq_ready;
  logic [AW-1:0]    wreq_addr = '0;
  logic [WIDTH-1:0] wreq_data = '0;
  logic             init_done;
  logic             sram_r_en;
  logic [AW-1:0]    sram_r_addr;
  logic [WIDTH-1:0] sram_r_data;
  logic             sram_w_en;
  logic [AW-1:0]    sram_w_addr;
  logic [WIDTH-1:0] sram_w_data;
  logic             sram_w_mask;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_access_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .rreq_valid  (rreq_valid),
    .rreq_ready  (rreq_ready),
    .rreq_addr   (rreq_addr),
    .rresp_valid (rresp_valid),
    .rresp_ready (rresp_ready),
    .rresp_data  (rresp_data),
    .wreq_valid  (wreq_valid),
    .wreq_ready  (wreq_ready),
    .wreq_addr   (wreq_addr),
    .wreq_data   (wreq_data),
    .init_done   (init_done),
    .sram_r_en   (sram_r_en),
    .sram_r_addr (sram_r_addr),
    .sram_r_data (sram_r_data),
    .sram_w_en   (sram_w_en),
    .sram_w_addr (sram_w_addr),
    .sram_w_data (sram_w_data),
    .sram_w_mask (sram_w_mask)
  );

  function automatic logic [WIDTH-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural macro: read-old-data on collision, garbage output when not read.
  logic [WIDTH-1:0] mem [DEPTH];
  bit               seeded = 1'b0;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= rand_word();
      seeded <= 1'b1;
    end
    if (sram_r_en) sram_r_data <= mem[sram_r_addr];
    else           sram_r_data <= rand_word();
    if (sram_w_en && sram_w_mask) mem[sram_w_addr] <= sram_w_data;
  end

  // Reference model: array contents plus queue of expected responses.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int               rel_cnt = 0;
  bit               model_valid = 1'b0;

  always @(negedge clock) begin
    bit               done, rdy_exp, rfire, wfire;
    logic [WIDTH-1:0] v;
    if (reset) begin
      rel_cnt     = 0;
      model_valid = 1'b0;
      exp_q.delete();
      if (INIT_EN) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      done = (rel_cnt >= READY_AT);
      if (rel_cnt < 1000000) rel_cnt++;
      rdy_exp = done && (!model_valid || rresp_ready);
      rfire   = rreq_valid && rdy_exp;
      wfire   = wreq_valid && done;
      check("init_done", init_done, done);
      check("rreq_ready", rreq_ready, rdy_exp);
      check("wreq_ready", wreq_ready, done);
      check("sram_r_en", sram_r_en, rfire);
      if (rfire) check("sram_r_addr", sram_r_addr, rreq_addr);
      if (done || !INIT_EN) check("sram_w_en", sram_w_en, wfire);
      if (wfire) begin
        check("sram_w_addr", sram_w_addr, wreq_addr);
        check("sram_w_data", sram_w_data, wreq_data);
        check("sram_w_mask", sram_w_mask, 1'b1);
      end
      check("rresp_valid", rresp_valid, model_valid);
      if (model_valid && exp_q.size() > 0) begin
        check("rresp_data", rresp_data, exp_q[0]);
        if (rresp_ready) void'(exp_q.pop_front());
      end
      if (rfire) begin
        v = (wfire && wreq_addr == rreq_addr) ? wreq_data : ref_mem[rreq_addr];
        exp_q.push_back(v);
      end
      if (wfire) ref_mem[wreq_addr] = wreq_data;
      model_valid = rfire || (model_valid && !rresp_ready);
    end
  end

  // Every driver task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_fire(input bit is_read);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      ok = is_read ? rreq_ready : wreq_ready;
      step();
    end
    check(is_read ? "read_accept" : "write_accept", ok, 1'b1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wreq_valid = 1'b1;
    wreq_addr  = a;
    wreq_data  = d;
    wait_fire(1'b0);
    wreq_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rreq_valid = 1'b1;
    rreq_addr  = a;
    wait_fire(1'b1);
    rreq_valid = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] e);
    rresp_ready = 1'b1;
    do_read(a);
    @(negedge clock);
    check({tag, "_valid"}, rresp_valid, 1'b1);
    check(tag, rresp_data, e);
    step();
  endtask

  task automatic sweep_check(input int n, input bit finish);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      check("sweep_w_en", sram_w_en, 1'b1);
      check("sweep_w_addr", sram_w_addr, k);
      check("sweep_w_data", sram_w_data, '0);
      check("sweep_rresp_valid", rresp_valid, 1'b0);
    end
    if (finish) begin
      @(negedge clock);
      check("sweep_end_w_en", sram_w_en, 1'b0);
      check("sweep_end_init_done", init_done, 1'b1);
    end
    step();
  endtask

  initial begin
    bit rf, wf;
    repeat (3) step();
    reset = 1'b0;

    // Bring-up: sweep (or client fill when the sweep is not built), then a read.
    if (INIT_EN) begin
      sweep_check(DEPTH, 1'b1);
      read_expect("post_init_rd5", 7'd5, '0);
    end else begin
      for (int a = 0; a < DEPTH; a++) do_write(AW'(a), WIDTH'(a * 32'h1357 + 3));
      read_expect("post_fill_rd5", 7'd5, WIDTH'(5 * 32'h1357 + 3));
    end

    do_write(7'd10, 51'h1_2345_6789);
    read_expect("rd10", 7'd10, 51'h1_2345_6789);

    // Same-cycle write and read of one address returns the new data.
    rreq_valid = 1'b1; rreq_addr = 7'd20;
    wreq_valid = 1'b1; wreq_addr = 7'd20; wreq_data = 51'h7;
    @(negedge clock);
    check("coll_rready", rreq_ready, 1'b1);
    check("coll_wready", wreq_ready, 1'b1);
    step();
    rreq_valid = 1'b0; wreq_valid = 1'b0;
    @(negedge clock);
    check("coll_valid", rresp_valid, 1'b1);
    check("coll_data", rresp_data, 51'h7);
    step();

    // Held response is immune to a write of its own address.
    do_write(7'd30, 51'hAA);
    rresp_ready = 1'b0;
    do_read(7'd30);
    wreq_valid = 1'b1; wreq_addr = 7'd30; wreq_data = 51'hBB;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("hold_valid", rresp_valid, 1'b1);
      check("hold_data", rresp_data, 51'hAA);
      check("hold_rready", rreq_ready, 1'b0);
      step();
      wreq_valid = 1'b0;
    end
    rresp_ready = 1'b1;
    @(negedge clock);
    check("hold_release_data", rresp_data, 51'hAA);
    check("hold_release_rready", rreq_ready, 1'b1);
    step();
    read_expect("rd30_after", 7'd30, 51'hBB);

    // Back-to-back reads at full throughput.
    for (int k = 0; k < 8; k++) do_write(AW'(k), WIDTH'(32'h100 + k));
    rresp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rreq_valid = 1'b1; rreq_addr = AW'(k);
      @(negedge clock);
      check("b2b_rready", rreq_ready, 1'b1);
      if (k > 0) begin
        check("b2b_valid", rresp_valid, 1'b1);
        check("b2b_data", rresp_data, WIDTH'(32'h100 + k - 1));
      end
      step();
    end
    rreq_valid = 1'b0;
    @(negedge clock);
    check("b2b_last_valid", rresp_valid, 1'b1);
    check("b2b_last_data", rresp_data, WIDTH'(32'h107));
    step();
    @(negedge clock);
    check("b2b_idle", rresp_valid, 1'b0);
    step();

    // Randomized traffic with backpressure and frequent address collisions.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      rf = rreq_valid && rreq_ready;
      wf = wreq_valid && wreq_ready;
      step();
      if (!rreq_valid || rf) begin
        rreq_valid = ($urandom_range(0, 99) < 60);
        rreq_addr  = AW'($urandom_range(0, 15));
      end
      if (!wreq_valid || wf) begin
        wreq_valid = ($urandom_range(0, 99) < 45);
        wreq_addr  = ($urandom_range(0, 3) == 0) ? rreq_addr : AW'($urandom_range(0, 15));
        wreq_data  = rand_word();
      end
      rresp_ready = ($urandom_range(0, 99) < 65);
    end
    rreq_valid = 1'b0; wreq_valid = 1'b0; rresp_ready = 1'b1;
    repeat (3) step();
    check("drain_empty", exp_q.size(), 0);

    // Reset while a response is held, then (with the sweep) reset mid-sweep.
    do_write(7'd40, 51'h55);
    rresp_ready = 1'b0;
    do_read(7'd40);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rresp_ready = 1'b1;
    if (INIT_EN) begin
      sweep_check(60, 1'b0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      sweep_check(DEPTH, 1'b1);
      read_expect("rd40_after_reset", 7'd40, '0);
    end else begin
      @(negedge clock);
      check("reset_rresp_valid", rresp_valid, 1'b0);
      step();
      read_expect("rd40_after_reset", 7'd40, 51'h55);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
